serial_adder_ctrl: RTL and testbench

- Bit-serial multi-bit adder/subtractor controller built around a single 1-bit full-adder cell: sum = a^b^c, carry = majority(a,b,c).
- Accepts two WIDTH-bit operands over a valid/ready handshake and feeds them LSB-first through the cell, one bit per clock.
- Holds the carry in a flip-flop between bits and returns the assembled result over a second valid/ready handshake.
- Trades area for latency; used wherever a wide adder is not justified.

---
 rtl/serial_adder_ctrl.sv | 117 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor controller around one full-adder cell.
// Operands in and results out over valid/ready handshakes.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic bit_s;
  logic bit_c;

  // The single full-adder cell working on the current LSBs.
  always_comb begin
    bit_s = a_q[0] ^ b_q[0] ^ c_q;
    bit_c = (a_q[0] & b_q[0]) |
            (a_q[0] & c_q) |
            (b_q[0] & c_q);
  end

  // Next-state and datapath update for IDLE/RUN/DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub | carry_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        r_d = r_q >> 1;
        r_d[WIDTH-1] = bit_s;
        c_d   = bit_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = r_d;
          cout_d  = bit_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset clearing every datapath flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH = 4).
// Random and directed operations against an arithmetic reference.
module tb_serial_adder_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_s;
  logic [W-1:0] b_s;
  logic         cin_s;
  logic         sub_s;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_s),
    .b         (b_s),
    .carry_in  (cin_s),
    .sub       (sub_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_op(input logic [W-1:0] x,
                                        input logic [W-1:0] y,
                                        input logic ci,
                                        input logic sb);
    logic [W:0] r;
    logic [W-1:0] yy;
    yy = sb ? ~y : y;
    r = {1'b0, x} + {1'b0, yy} + (W+1)'(sb ? 1'b1 : ci);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    if (g >= 50) chk("ready_timeout", 0, 1);
    a_s = x;
    b_s = y;
    cin_s = ci;
    sub_s = sb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a_s = W'($urandom);
    b_s = W'($urandom);
    cin_s = 1'($urandom);
    sub_s = 1'($urandom);
  endtask

  task automatic wait_result(input string tag, input logic [W:0] exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, W);
    chk({tag, "_sum"}, sum, exp[W-1:0]);
    chk({tag, "_cout"}, carry_out, exp[W]);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic ci,
                       input logic sb, input logic [W:0] exp);
    out_ready = 1'b1;
    accept(x, y, ci, sb);
    wait_result(tag, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic ci;
    logic sb;
    logic seen;
    logic [W:0] q[$];
    logic [W:0] e;
    int acc;
    int got;
    int t;
    int last;
    logic will_acc;

    rst = 1'b1;
    in_valid = 1'b1;
    a_s = 4'hF;
    b_s = 4'hF;
    cin_s = 1'b1;
    sub_s = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", carry_out, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_no_start", busy, 0);

    do_op("add1", 4'b0101, 4'b0011, 1'b0, 1'b0, 5'b0_1000);
    do_op("add2", 4'b1111, 4'b0001, 1'b1, 1'b0, 5'b1_0001);
    do_op("sub1", 4'b0111, 4'b0010, 1'b1, 1'b1, 5'b1_0101);
    do_op("sub2", 4'b0010, 4'b0111, 1'b1, 1'b1, 5'b0_1011);

    for (int i = 0; i < 8; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      ci = 1'($urandom);
      sb = 1'($urandom);
      do_op("rand", x, y, ci, sb, ref_op(x, y, ci, sb));
    end

    out_ready = 1'b0;
    accept(4'd9, 4'd5, 1'b0, 1'b0);
    wait_result("bp", 5'd14);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      a_s = W'($urandom);
      b_s = W'($urandom);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", sum, 4'd14);
      chk("bp_cout", carry_out, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_idle", in_ready, 1);
    chk("bp_busy", busy, 0);
    chk("bp_valid_low", out_valid, 0);
    do_op("bp_next", 4'd3, 4'd6, 1'b1, 1'b0, 5'd10);

    accept(4'b1111, 4'b1111, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_sum", sum, 0);
    chk("mrst_cout", carry_out, 0);
    seen = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("mrst_no_valid", seen, 0);
    do_op("mrst_leak", 4'b0000, 4'b0000, 1'b0, 1'b0, 5'd0);

    acc = 0;
    got = 0;
    t = 0;
    last = -1;
    out_ready = 1'b1;
    x = W'($urandom);
    y = W'($urandom);
    ci = 1'($urandom);
    sb = 1'($urandom);
    a_s = x;
    b_s = y;
    cin_s = ci;
    sub_s = sb;
    in_valid = 1'b1;
    while ((acc < 10 || got < acc) && t < 400) begin
      will_acc = in_ready && in_valid;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("b2b_spurious", 1, 0);
        end else begin
          e = q.pop_front();
          chk("b2b_sum", sum, e[W-1:0]);
          chk("b2b_cout", carry_out, e[W]);
        end
        got++;
      end
      tick();
      t++;
      if (will_acc) begin
        if (last >= 0) chk("b2b_ii", t - last, W + 2);
        last = t;
        q.push_back(ref_op(x, y, ci, sb));
        acc++;
        x = W'($urandom);
        y = W'($urandom);
        ci = 1'($urandom);
        sb = 1'($urandom);
        a_s = x;
        b_s = y;
        cin_s = ci;
        sub_s = sb;
        if (acc == 10) in_valid = 1'b0;
      end
    end
    if (t >= 400) chk("b2b_timeout", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
